fact_bus_master: RTL
====================

Name: fact_bus_master

Overview:
- Bus initiator that drives the memory-mapped factorial core from the initiator side of the existing m_* bus.
- Accepts an operand on a valid/ready command port and programs the core's registers.
- Waits for the core's interrupt, reads the 128-bit result, clears the core, and returns the result on a valid/ready response port.
- Replaces software or testbench sequencing of the core. Sits between a host-side requester and the core's m_* port.

Parameters:
- BASE_ADDR, 16'h7000, base of the core register block.
- TIMEOUT_CYCLES, 65535, maximum WAIT_DONE cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  operand command valid.
- cmd_ready  out  1  block can accept a command (IDLE only).
- cmd_operand  in  64  factorial operand N.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  128  {RESULT_H, RESULT_L}.
- rsp_error  out  1  qualifies rsp_valid; 1 means timeout abort.
- m_req  out  1  bus request.
- m_grant  in  1  bus grant from arbiter.
- m_wr  out  1  1 = write, 0 = read.
- m_addr  out  16  register address.
- m_dout  out  64  write data to core.
- m_din  in  64  read data from core; valid in a granted read cycle.
- interrupt  in  1  core done interrupt, level.

Behaviour:
- Register offsets from BASE_ADDR:
  - OPSTART 0x00
  - OPCLEAR 0x08
  - OPDONE 0x10
  - INTREN 0x18
  - OPERAND 0x20
  - RESULT_H 0x28
  - RESULT_L 0x30
- Bus transfer rule:
  - A transfer completes on a rising edge where m_req=1 and m_grant=1.
  - Writes are taken by the core on that edge.
  - For reads, m_din is sampled on that same edge.
  - m_wr, m_addr and m_dout must stay stable while m_req=1 and m_grant=0.
- m_req is held high continuously from leaving IDLE until entering RESP; it is low in IDLE and RESP.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_result=0, m_req=0, m_wr=0, m_addr=0, m_dout=0; state=IDLE.
- State sequence. Each bus state advances only on a granted edge.
  - IDLE: cmd_ready=1. On cmd_valid, latch the operand and go to W_INTREN.
  - W_INTREN: write 1 to INTREN.
  - W_OPERAND: write the latched operand to OPERAND.
  - W_CLR1: write 1 to OPCLEAR.
  - W_CLR0: write 0 to OPCLEAR.
  - W_START: write 1 to OPSTART.
  - WAIT_DONE:
    - m_req stays 1, with a read of OPDONE driven on the bus.
    - Exit when interrupt=1 is sampled, or when a granted read returns m_din[0]=1.
    - Go to R_RESH.
  - R_RESH: read RESULT_H into result[127:64].
  - R_RESL: read RESULT_L into result[63:0].
  - F_CLR1: write 1 to OPCLEAR.
  - F_CLR0: write 0 to OPCLEAR.
  - RESP: rsp_valid=1, m_req=0. On rsp_ready, go to IDLE.
- Command acceptance: cmd_ready=0 in every state except IDLE, and a cmd_valid outside IDLE is ignored.
- Response hold: rsp_result and rsp_error are stable while rsp_valid=1. rsp_valid and rsp_ready in the same cycle completes the handshake, and rsp_valid is 0 on the next cycle.
- Minimum latency with grant always high: 5 setup writes + 1 WAIT_DONE cycle + 2 reads + 2 clears + RESP = 11 cycles from cmd accept to rsp_valid, excluding core compute time.
- Timeout:
  - Counter starts at 0 on entering WAIT_DONE and increments every cycle.
  - At TIMEOUT_CYCLES, go to F_CLR1 with an error flag; the result reads are skipped.
  - In RESP: rsp_error=1, rsp_result=0.
- Simultaneous interrupt and timeout expiry on the same edge: the interrupt wins (normal path).
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. m_req drops even if grant is high, and no further bus writes occur.
- Interrupt asserted outside WAIT_DONE is ignored.
- An operand of 0 is passed through unchanged; the core defines 0! = 1.

Decomposition:
- Shared package fact_bus_pkg holds:
  - register offset constants (OPSTART..RESULT_L);
  - the state enumeration;
  - the bus transfer width constants (address 16, data 64).
- Optional sub-module fact_bus_txn: single-transfer engine.
  - Holds m_req, m_wr, m_addr and m_dout stable until grant.
  - Pulses done and captures rdata.
- The top FSM sequences fact_bus_txn.

Test Plan (bench uses a behavioural core responder with an arbiter that can stall grant):
- N=1, grant tied high: bus write sequence is 0x7018←1, 0x7020←1, 0x7008←1, 0x7008←0, 0x7000←1. Result reads follow, then rsp_valid with rsp_result=128'h1 and rsp_error=0.
- N=10: rsp_result=128'h375F00 (3628800). N=21: RESULT_H=64'h2, RESULT_L=64'hC5077D36B8C40000.
- Grant held low 3 cycles during W_OPERAND:
  - m_req=1 with m_addr=0x7020 and m_dout=N stable for all 3 cycles.
  - Exactly one OPERAND write is recorded.
- Responder never interrupts and OPDONE reads 0, TIMEOUT_CYCLES=100:
  - rsp_valid after 100 WAIT_DONE cycles with rsp_error=1 and rsp_result=0.
  - OPCLEAR 1/0 is written.
- Response backpressure: rsp_ready low 5 cycles, so rsp_valid and rsp_result are held. A second cmd_valid during this time is not accepted (cmd_ready=0).
- reset_n low for 1 cycle during WAIT_DONE: next cycle m_req=0, state IDLE, cmd_ready=1. A following N=5 run returns 128'h78.

Source files
------------

// File: rtl/fact_bus_pkg.sv
// Shared definitions for the factorial-core bus master: register map,
// bus widths and the sequencing state enumeration.
package fact_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    // Register offsets inside the core register block
    localparam logic [ADDR_W-1:0] OFF_OPSTART  = 16'h0000;
    localparam logic [ADDR_W-1:0] OFF_OPCLEAR  = 16'h0008;
    localparam logic [ADDR_W-1:0] OFF_OPDONE   = 16'h0010;
    localparam logic [ADDR_W-1:0] OFF_INTREN   = 16'h0018;
    localparam logic [ADDR_W-1:0] OFF_OPERAND  = 16'h0020;
    localparam logic [ADDR_W-1:0] OFF_RESULT_H = 16'h0028;
    localparam logic [ADDR_W-1:0] OFF_RESULT_L = 16'h0030;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_W_INTREN  = 4'd1,
        ST_W_OPERAND = 4'd2,
        ST_W_CLR1    = 4'd3,
        ST_W_CLR0    = 4'd4,
        ST_W_START   = 4'd5,
        ST_WAIT_DONE = 4'd6,
        ST_R_RESH    = 4'd7,
        ST_R_RESL    = 4'd8,
        ST_F_CLR1    = 4'd9,
        ST_F_CLR0    = 4'd10,
        ST_RESP      = 4'd11
    } fsm_state_t;

    // True for every state that owns the bus (m_req held high)
    function automatic logic is_bus_state(input fsm_state_t s);
        return (s != ST_IDLE) && (s != ST_RESP);
    endfunction

endpackage

// File: rtl/fact_bus_txn.sv
// Single-transfer engine: registers the bus request presented by the
// sequencer and flags the edge on which the arbiter grants it.
// The sequencer only changes its request after a granted edge, so the
// registered bus signals stay stable while the grant is withheld. The one
// exception is the OPDONE poll, which may be abandoned on interrupt or
// timeout; that read has no side effects in the core.
module fact_bus_txn
    import fact_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata
);

    logic              r_req;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Bus output registers, loaded every cycle from the sequencer's request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 64'd0;
        end else begin
            r_req   <= i_req;
            r_wr    <= i_wr;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign m_req   = r_req;
    assign m_wr    = r_wr;
    assign m_addr  = r_addr;
    assign m_dout  = r_wdata;
    // Transfer completes on this edge; read data is valid alongside it
    assign o_done  = r_req & m_grant;
    assign o_rdata = m_din;

endmodule

// File: rtl/fact_bus_master.sv
// Bus initiator that programs the factorial core, waits for completion
// (interrupt or OPDONE poll, with optional timeout), reads the 128-bit
// result, clears the core and returns the result on a valid/ready port.
module fact_bus_master
    import fact_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = 16'h7000,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [63:0]  cmd_operand,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_result,
    output logic         rsp_error,
    output logic         m_req,
    input  logic         m_grant,
    output logic         m_wr,
    output logic [15:0]  m_addr,
    output logic [63:0]  m_dout,
    input  logic [63:0]  m_din,
    input  logic         interrupt
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    fsm_state_t    r_state;
    fsm_state_t    w_next_state;
    logic [63:0]   r_operand;
    logic [127:0]  r_result;
    logic          r_err;
    logic [31:0]   r_count;
    logic          r_cmd_ready;
    logic          r_rsp_valid;

    logic          w_done;
    logic [63:0]   w_rdata;
    logic          w_expired;
    logic          w_core_done;
    logic          w_bus_req;
    logic          w_bus_wr;
    logic [15:0]   w_bus_addr;
    logic [63:0]   w_bus_wdata;
    logic          w_cmd_ready;
    logic          w_rsp_valid;

    // Timeout counts WAIT_DONE cycles; a zero limit disables it
    assign w_expired   = (TIMEOUT_CYCLES != 0) && (r_count == TIMEOUT_LAST);
    // Completion seen either as the level interrupt or a granted OPDONE=1 read
    assign w_core_done = interrupt | (w_done & w_rdata[0]);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: bus states advance only on a granted edge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_next_state = ST_W_INTREN;
                else           w_next_state = ST_IDLE;
            end
            ST_W_INTREN: begin
                if (w_done) w_next_state = ST_W_OPERAND;
                else        w_next_state = ST_W_INTREN;
            end
            ST_W_OPERAND: begin
                if (w_done) w_next_state = ST_W_CLR1;
                else        w_next_state = ST_W_OPERAND;
            end
            ST_W_CLR1: begin
                if (w_done) w_next_state = ST_W_CLR0;
                else        w_next_state = ST_W_CLR1;
            end
            ST_W_CLR0: begin
                if (w_done) w_next_state = ST_W_START;
                else        w_next_state = ST_W_CLR0;
            end
            ST_W_START: begin
                if (w_done) w_next_state = ST_WAIT_DONE;
                else        w_next_state = ST_W_START;
            end
            ST_WAIT_DONE: begin
                // Completion has priority over a coincident timeout
                if (w_core_done)    w_next_state = ST_R_RESH;
                else if (w_expired) w_next_state = ST_F_CLR1;
                else                w_next_state = ST_WAIT_DONE;
            end
            ST_R_RESH: begin
                if (w_done) w_next_state = ST_R_RESL;
                else        w_next_state = ST_R_RESH;
            end
            ST_R_RESL: begin
                if (w_done) w_next_state = ST_F_CLR1;
                else        w_next_state = ST_R_RESL;
            end
            ST_F_CLR1: begin
                if (w_done) w_next_state = ST_F_CLR0;
                else        w_next_state = ST_F_CLR1;
            end
            ST_F_CLR0: begin
                if (w_done) w_next_state = ST_RESP;
                else        w_next_state = ST_F_CLR0;
            end
            ST_RESP: begin
                if (rsp_ready) w_next_state = ST_IDLE;
                else           w_next_state = ST_RESP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output register lines up with its state
    always_comb begin
        w_bus_req   = is_bus_state(w_next_state);
        w_bus_wr    = 1'b0;
        w_bus_addr  = 16'h0000;
        w_bus_wdata = 64'd0;
        w_cmd_ready = (w_next_state == ST_IDLE);
        w_rsp_valid = (w_next_state == ST_RESP);
        case (w_next_state)
            ST_W_INTREN: begin
                w_bus_wr    = 1'b1;
                w_bus_addr  = BASE_ADDR + OFF_INTREN;
                w_bus_wdata = 64'd1;
            end
            ST_W_OPERAND: begin
                w_bus_wr    = 1'b1;
                w_bus_addr  = BASE_ADDR + OFF_OPERAND;
                w_bus_wdata = r_operand;
            end
            ST_W_CLR1, ST_F_CLR1: begin
                w_bus_wr    = 1'b1;
                w_bus_addr  = BASE_ADDR + OFF_OPCLEAR;
                w_bus_wdata = 64'd1;
            end
            ST_W_CLR0, ST_F_CLR0: begin
                w_bus_wr    = 1'b1;
                w_bus_addr  = BASE_ADDR + OFF_OPCLEAR;
                w_bus_wdata = 64'd0;
            end
            ST_W_START: begin
                w_bus_wr    = 1'b1;
                w_bus_addr  = BASE_ADDR + OFF_OPSTART;
                w_bus_wdata = 64'd1;
            end
            ST_WAIT_DONE: w_bus_addr = BASE_ADDR + OFF_OPDONE;
            ST_R_RESH:    w_bus_addr = BASE_ADDR + OFF_RESULT_H;
            ST_R_RESL:    w_bus_addr = BASE_ADDR + OFF_RESULT_L;
            default: begin
                w_bus_wr    = 1'b0;
                w_bus_addr  = 16'h0000;
                w_bus_wdata = 64'd0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_cmd_ready <= w_cmd_ready;
            r_rsp_valid <= w_rsp_valid;
        end
    end

    // Operand latch, result capture, error flag and WAIT_DONE cycle counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_operand <= 64'd0;
            r_result  <= 128'd0;
            r_err     <= 1'b0;
            r_count   <= 32'd0;
        end else begin
            if (r_state == ST_WAIT_DONE) r_count <= r_count + 32'd1;
            else                         r_count <= 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_operand <= cmd_operand;
                        r_result  <= 128'd0;
                        r_err     <= 1'b0;
                    end else begin
                        r_operand <= r_operand;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_next_state == ST_F_CLR1) r_err <= 1'b1;
                    else                           r_err <= r_err;
                end
                ST_R_RESH: begin
                    if (w_done) r_result[127:64] <= w_rdata;
                    else        r_result         <= r_result;
                end
                ST_R_RESL: begin
                    if (w_done) r_result[63:0] <= w_rdata;
                    else        r_result       <= r_result;
                end
                default: r_result <= r_result;
            endcase
        end
    end

    fact_bus_txn u_txn (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (w_bus_req),
        .i_wr    (w_bus_wr),
        .i_addr  (w_bus_addr),
        .i_wdata (w_bus_wdata),
        .m_grant (m_grant),
        .m_din   (m_din),
        .m_req   (m_req),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_dout  (m_dout),
        .o_done  (w_done),
        .o_rdata (w_rdata)
    );

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_error  = r_err;

endmodule
